midi_voice_alloc: RTL and testbench
===================================

MIDI_VOICE_ALLOC -- requirements
Module: midi_voice_alloc

Interface
REQ-001 The module SHALL have parameter OMNI, default 1, meaning 1 = accept channel messages on any MIDI channel.
REQ-002 The module SHALL have parameter CHANNEL, default 4'd0, meaning the accepted MIDI channel when OMNI = 0.
REQ-003 Port clk  input  1  system clock; all state SHALL change only on the rising edge.
REQ-004 Port rst  input  1  reset; one clock, reset is asynchronous and active-low.
REQ-005 Port ce  input  1  clock enable; when 0, no state SHALL change.
REQ-006 Port rx_data  input  8  received MIDI byte.
REQ-007 Port rx_valid  input  1  rx_data is valid this cycle; a byte SHALL be consumed only when rx_valid = 1 and ce = 1.
REQ-008 Port program  output  7  current program number.
REQ-009 Ports note_num_0..note_num_3  output  7 each  note number held by voice slot 0..3.
REQ-010 Ports note_vel_0..note_vel_3  output  7 each  velocity of slot 0..3; 0 means the slot is free and silent.

Function
REQ-011 All outputs SHALL be registered, with no combinational path from any input to any output.
REQ-012 The parser SHALL have states IDLE (no running status), WAIT_D1 and WAIT_D2.
REQ-013 A status byte 0x80-0xEF SHALL be stored as the running status and move the parser to WAIT_D1, discarding any partial message.
REQ-014 A status byte 0xF0-0xF7 SHALL clear the running status and move the parser to IDLE.
REQ-015 A status byte 0xF8-0xFF SHALL be ignored completely: parser state, running status and outputs SHALL remain unchanged, and a message in progress SHALL continue.
REQ-016 A data byte (bit7 = 0) received in IDLE SHALL be ignored.
REQ-017 In WAIT_D1, a data byte SHALL be latched as D1; for 0xCn the parser SHALL then return to WAIT_D1, and for every other type it SHALL move to WAIT_D2.
REQ-018 In WAIT_D2, a data byte SHALL be taken as D2, the message SHALL complete, and the parser SHALL return to WAIT_D1 with the running status kept.
REQ-019 A completed message whose channel does not match (OMNI = 0 and the low nibble is not CHANNEL), or whose type is not 0x8n, 0x9n, 0xBn or 0xCn, SHALL have no effect.
REQ-020 Outputs SHALL update on the clock edge that consumes the final byte of a message, so they are visible in the following cycle.
REQ-021 Program change 0xCn: program SHALL be set to D1.
REQ-022 Note off (0x8n, or 0x9n with D2 = 0): every slot with note_num = D1 and note_vel != 0 SHALL have note_vel cleared to 0, and its note_num SHALL be kept.
REQ-023 Note on (0x9n, D2 != 0), priority 1: if a slot already holds note_num = D1 with note_vel != 0, that slot's note_vel SHALL be set to D2.
REQ-024 Note on, priority 2: otherwise the lowest-index free slot SHALL be loaded with {D1, D2}.
REQ-025 Note on, priority 3: otherwise the slot at the 2-bit steal pointer SHALL be loaded with {D1, D2}, and the pointer SHALL increment modulo 4, wrapping from 3 to 0.
REQ-026 The steal pointer SHALL change only on a steal.
REQ-027 Control change 0xBn with D1 = 120 or D1 = 123 SHALL clear all four note_vel to 0; any other controller number SHALL have no effect.
REQ-028 At most one message SHALL complete per cycle, and back-to-back bytes on consecutive cycles SHALL be accepted without loss.

Reset
REQ-029 While rst = 0, the parser SHALL be in IDLE, the running status and steal pointer SHALL be 0, and program and all note_num/note_vel outputs SHALL be 0, independent of clk and ce.
REQ-030 Reset asserted mid-message SHALL discard the partial message, and after release a data byte SHALL be ignored until a status byte is received.

Verification
REQ-031 Bytes 0x90,0x3C,0x64 -> the next cycle shows note_num_0 = 60 and note_vel_0 = 100, and all other slots are 0.
REQ-032 Running status: 0x90,0x3C,0x40,0x40,0x50,0x3C,0x00 -> slot0 = {60,64} then {60,0}, and slot1 = {64,80}.
REQ-033 Five note-ons 60..64 (vel 10): the first four fill slots 0-3, the fifth overwrites slot0 with {64,10}, and a sixth note-on 65 overwrites slot1.
REQ-034 0x90,0x3C,0xF8,0x64 -> the message completes with slot0 = {60,100}; 0x90,0x3C,0x80,... -> the partial note-on is discarded.
REQ-035 0xC5,0x12 then 0xB0,0x7B,0x00 with voices active -> program = 18 and all note_vel = 0; with OMNI = 0 and CHANNEL = 1, 0x90,0x3C,0x64 -> no change.
REQ-036 rst pulsed low between D1 and D2, then 0x64 -> no output change, and all outputs read 0 during reset.

Source files
------------

// File: rtl/midi_voice_alloc_if.sv
// Received-byte bus feeding the MIDI voice allocator: one byte per cycle, qualified by rx_valid.
interface midi_voice_alloc_if;
    logic [7:0] rx_data;
    logic       rx_valid;

    modport master (output rx_data, output rx_valid);
    modport slave  (input  rx_data, input  rx_valid);
endinterface

// File: rtl/midi_voice_alloc.sv
// MIDI byte-stream parser with running status driving a four-slot note/voice allocator.
// Handles note on/off, program change and all-notes-off; all outputs come straight from registers.
module midi_voice_alloc #(
    parameter int unsigned OMNI    = 32'd1,
    parameter logic [3:0]  CHANNEL = 4'd0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ce,
    midi_voice_alloc_if.slave        rx,
    output logic [6:0]               program_num,
    output logic [6:0]               note_num_0,
    output logic [6:0]               note_num_1,
    output logic [6:0]               note_num_2,
    output logic [6:0]               note_num_3,
    output logic [6:0]               note_vel_0,
    output logic [6:0]               note_vel_1,
    output logic [6:0]               note_vel_2,
    output logic [6:0]               note_vel_3
);

    localparam int NUM_SLOTS = 32'sd4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_D1 = 2'd1,
        ST_WAIT_D2 = 2'd2
    } state_t;

    state_t      state_r, state_nxt_s;
    logic [7:0]  status_r, status_nxt_s;
    logic [6:0]  d1_r, d1_nxt_s;
    logic        take_s;
    logic        msg_done_s;
    logic [6:0]  msg_d1_s, msg_d2_s;
    logic        chan_ok_s;

    logic [6:0]  program_r, program_nxt_s;
    logic [1:0]  steal_r, steal_nxt_s;
    logic [6:0]  num_r [NUM_SLOTS];
    logic [6:0]  vel_r [NUM_SLOTS];
    logic [6:0]  num_nxt_s [NUM_SLOTS];
    logic [6:0]  vel_nxt_s [NUM_SLOTS];
    logic        hit_s, free_s;
    logic [1:0]  hit_idx_s, free_idx_s;

    assign take_s    = rx.rx_valid & ce;
    assign chan_ok_s = (OMNI != 32'd0) || (status_r[3:0] == CHANNEL);

    // Parser state, running status and latched first data byte
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r  <= ST_IDLE;
            status_r <= 8'h00;
            d1_r     <= 7'd0;
        end else begin
            state_r  <= state_nxt_s;
            status_r <= status_nxt_s;
            d1_r     <= d1_nxt_s;
        end
    end

    // Parser next state; flags a completed message together with its data bytes
    always_comb begin
        state_nxt_s  = state_r;
        status_nxt_s = status_r;
        d1_nxt_s     = d1_r;
        msg_done_s   = 1'b0;
        msg_d1_s     = 7'd0;
        msg_d2_s     = 7'd0;
        if (take_s) begin
            if (rx.rx_data[7]) begin
                if (rx.rx_data < 8'hF0) begin
                    status_nxt_s = rx.rx_data;
                    state_nxt_s  = ST_WAIT_D1;
                end else if (rx.rx_data < 8'hF8) begin
                    status_nxt_s = 8'h00;
                    state_nxt_s  = ST_IDLE;
                end else begin
                    // Real-time bytes are transparent to a message in progress
                    state_nxt_s  = state_r;
                end
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        state_nxt_s = ST_IDLE;
                    end
                    ST_WAIT_D1: begin
                        d1_nxt_s = rx.rx_data[6:0];
                        if (status_r[7:4] == 4'hC) begin
                            msg_done_s  = 1'b1;
                            msg_d1_s    = rx.rx_data[6:0];
                            state_nxt_s = ST_WAIT_D1;
                        end else begin
                            state_nxt_s = ST_WAIT_D2;
                        end
                    end
                    ST_WAIT_D2: begin
                        msg_done_s  = 1'b1;
                        msg_d1_s    = d1_r;
                        msg_d2_s    = rx.rx_data[6:0];
                        state_nxt_s = ST_WAIT_D1;
                    end
                    default: begin
                        state_nxt_s = ST_IDLE;
                    end
                endcase
            end
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Voice allocation and program update for a completed, accepted message
    always_comb begin
        program_nxt_s = program_r;
        steal_nxt_s   = steal_r;
        hit_s         = 1'b0;
        hit_idx_s     = 2'd0;
        free_s        = 1'b0;
        free_idx_s    = 2'd0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            num_nxt_s[i] = num_r[i];
            vel_nxt_s[i] = vel_r[i];
        end
        // Descending scan so the lowest matching index is the one that sticks
        for (int i = NUM_SLOTS - 32'sd1; i >= 32'sd0; i--) begin
            if ((vel_r[i] != 7'd0) && (num_r[i] == msg_d1_s)) begin
                hit_s     = 1'b1;
                hit_idx_s = 2'(i);
            end
            if (vel_r[i] == 7'd0) begin
                free_s     = 1'b1;
                free_idx_s = 2'(i);
            end
        end
        if (msg_done_s && chan_ok_s) begin
            case (status_r[7:4])
                4'h8, 4'h9: begin
                    if ((status_r[7:4] == 4'h8) || (msg_d2_s == 7'd0)) begin
                        for (int i = 0; i < NUM_SLOTS; i++) begin
                            if ((num_r[i] == msg_d1_s) && (vel_r[i] != 7'd0)) begin
                                vel_nxt_s[i] = 7'd0;
                            end
                        end
                    end else if (hit_s) begin
                        vel_nxt_s[hit_idx_s] = msg_d2_s;
                    end else if (free_s) begin
                        num_nxt_s[free_idx_s] = msg_d1_s;
                        vel_nxt_s[free_idx_s] = msg_d2_s;
                    end else begin
                        num_nxt_s[steal_r] = msg_d1_s;
                        vel_nxt_s[steal_r] = msg_d2_s;
                        steal_nxt_s        = steal_r + 2'd1;
                    end
                end
                4'hB: begin
                    if ((msg_d1_s == 7'd120) || (msg_d1_s == 7'd123)) begin
                        for (int i = 0; i < NUM_SLOTS; i++) begin
                            vel_nxt_s[i] = 7'd0;
                        end
                    end else begin
                        steal_nxt_s = steal_r;
                    end
                end
                4'hC: begin
                    program_nxt_s = msg_d1_s;
                end
                default: begin
                    program_nxt_s = program_r;
                end
            endcase
        end else begin
            program_nxt_s = program_r;
        end
    end

    // Output registers: program, steal pointer and the voice slots
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            program_r <= 7'd0;
            steal_r   <= 2'd0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                num_r[i] <= 7'd0;
                vel_r[i] <= 7'd0;
            end
        end else begin
            program_r <= program_nxt_s;
            steal_r   <= steal_nxt_s;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                num_r[i] <= num_nxt_s[i];
                vel_r[i] <= vel_nxt_s[i];
            end
        end
    end

    assign program_num = program_r;
    assign note_num_0  = num_r[0];
    assign note_num_1  = num_r[1];
    assign note_num_2  = num_r[2];
    assign note_num_3  = num_r[3];
    assign note_vel_0  = vel_r[0];
    assign note_vel_1  = vel_r[1];
    assign note_vel_2  = vel_r[2];
    assign note_vel_3  = vel_r[3];

endmodule

// File: tb/tb_midi_voice_alloc.sv
// Scoreboard bench for midi_voice_alloc: an omni instance and a channel-1 instance share one byte stream.
module tb_midi_voice_alloc;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ce  = 1'b0;
    midi_voice_alloc_if bus ();

    logic [6:0]       a_prog, b_prog;
    logic [3:0][6:0]  a_num, a_vel, b_num, b_vel;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    midi_voice_alloc #(.OMNI(1), .CHANNEL(4'd0)) dut_a (
        .clk(clk), .rst(rst), .ce(ce), .rx(bus),
        .program_num(a_prog),
        .note_num_0(a_num[0]), .note_num_1(a_num[1]), .note_num_2(a_num[2]), .note_num_3(a_num[3]),
        .note_vel_0(a_vel[0]), .note_vel_1(a_vel[1]), .note_vel_2(a_vel[2]), .note_vel_3(a_vel[3])
    );

    midi_voice_alloc #(.OMNI(0), .CHANNEL(4'd1)) dut_b (
        .clk(clk), .rst(rst), .ce(ce), .rx(bus),
        .program_num(b_prog),
        .note_num_0(b_num[0]), .note_num_1(b_num[1]), .note_num_2(b_num[2]), .note_num_3(b_num[3]),
        .note_vel_0(b_vel[0]), .note_vel_1(b_vel[1]), .note_vel_2(b_vel[2]), .note_vel_3(b_vel[3])
    );

    // Reference model: message-level view (running status + collected data bytes)
    int         rs;
    logic [6:0] dq[$];
    logic [6:0] m_prog [2];
    logic [6:0] m_num  [2][4];
    logic [6:0] m_vel  [2][4];
    int         m_steal[2];
    logic [125:0] exp_q[$];

    task automatic model_reset();
        rs = -1;
        dq.delete();
        for (int m = 0; m < 2; m++) begin
            m_prog[m] = 7'd0;
            m_steal[m] = 0;
            for (int i = 0; i < 4; i++) begin
                m_num[m][i] = 7'd0;
                m_vel[m][i] = 7'd0;
            end
        end
    endtask

    task automatic model_exec(input int st, input logic [6:0] a, input logic [6:0] b);
        int typ;
        int hit;
        int fr;
        typ = st / 16;
        for (int m = 0; m < 2; m++) begin
            if (m == 1 && (st % 16) != 1) continue;
            if (typ == 8 || (typ == 9 && b == 7'd0)) begin
                for (int i = 0; i < 4; i++)
                    if (m_num[m][i] == a) m_vel[m][i] = 7'd0;
            end else if (typ == 9) begin
                hit = -1;
                fr = -1;
                for (int i = 0; i < 4; i++) begin
                    if (m_vel[m][i] != 7'd0 && m_num[m][i] == a) hit = i;
                    if (m_vel[m][i] == 7'd0 && fr < 0) fr = i;
                end
                if (hit >= 0) begin
                    m_vel[m][hit] = b;
                end else if (fr >= 0) begin
                    m_num[m][fr] = a;
                    m_vel[m][fr] = b;
                end else begin
                    m_num[m][m_steal[m]] = a;
                    m_vel[m][m_steal[m]] = b;
                    m_steal[m] = (m_steal[m] + 1) % 4;
                end
            end else if (typ == 11) begin
                if (a == 7'd120 || a == 7'd123)
                    for (int i = 0; i < 4; i++) m_vel[m][i] = 7'd0;
            end else if (typ == 12) begin
                m_prog[m] = a;
            end
        end
    endtask

    task automatic model_byte(input logic [7:0] b);
        int need;
        if (b >= 8'hF8) begin
            // real-time: invisible
        end else if (b >= 8'hF0) begin
            rs = -1;
            dq.delete();
        end else if (b[7]) begin
            rs = int'(b);
            dq.delete();
        end else if (rs >= 0) begin
            dq.push_back(b[6:0]);
            need = (rs / 16 == 12) ? 1 : 2;
            if (dq.size() == need) begin
                model_exec(rs, dq[0], (need == 2) ? dq[1] : 7'd0);
                dq.delete();
            end
        end
    endtask

    function automatic logic [62:0] model_snap(input int m);
        return {m_prog[m], m_num[m][0], m_num[m][1], m_num[m][2], m_num[m][3],
                m_vel[m][0], m_vel[m][1], m_vel[m][2], m_vel[m][3]};
    endfunction

    function automatic logic [125:0] dut_snap();
        return {a_prog, a_num[0], a_num[1], a_num[2], a_num[3], a_vel[0], a_vel[1], a_vel[2], a_vel[3],
                b_prog, b_num[0], b_num[1], b_num[2], b_num[3], b_vel[0], b_vel[1], b_vel[2], b_vel[3]};
    endfunction

    task automatic send(input logic [7:0] b, input logic v, input logic c);
        @(negedge clk);
        bus.rx_data  = b;
        bus.rx_valid = v;
        ce           = c;
        if (v && c) begin
            model_byte(b);
            exp_q.push_back({model_snap(0), model_snap(1)});
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.rx_valid = 1'b0;
            ce           = 1'b1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.rx_valid = 1'b0;
        rst = 1'b0;
        model_reset();
        #1;
        total++;
        if (dut_snap() !== 126'd0) begin
            bad++;
            $display("FAIL reset_zero got=%h want=0", dut_snap());
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic check_slot(input string nm, input int m, input int idx,
                              input logic [6:0] n, input logic [6:0] v);
        logic [6:0] gn, gv;
        gn = (m == 0) ? a_num[idx] : b_num[idx];
        gv = (m == 0) ? a_vel[idx] : b_vel[idx];
        total++;
        if (gn !== n || gv !== v) begin
            bad++;
            $display("FAIL %s dut%0d slot%0d got={%0d,%0d} want={%0d,%0d}", nm, m, idx, gn, gv, n, v);
        end
    endtask

    // Monitor: every consumed byte yields one expected snapshot, compared the cycle after
    initial begin
        logic took;
        logic [125:0] e;
        forever begin
            @(posedge clk);
            took = bus.rx_valid && ce && rst;
            #1;
            if (took) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL sb_underflow got=%h want=queued_entry", dut_snap());
                end else begin
                    e = exp_q.pop_front();
                    if (dut_snap() !== e) begin
                        bad++;
                        $display("FAIL sb_compare got=%h want=%h", dut_snap(), e);
                    end
                end
            end
        end
    end

    initial begin
        logic [7:0] sts [12];
        logic [7:0] b;
        int r;
        sts = '{8'h80, 8'h90, 8'h90, 8'h91, 8'h81, 8'hB0, 8'hB1, 8'hC0, 8'hC1, 8'hA0, 8'hE0, 8'h99};
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        model_reset();
        #3 rst = 1'b0;
        #2;
        total++;
        if (dut_snap() !== 126'd0) begin
            bad++;
            $display("FAIL init_reset got=%h want=0", dut_snap());
        end
        @(negedge clk);
        rst = 1'b1;

        // Basic note-on; channel-1 instance must ignore it
        send(8'h90, 1'b1, 1'b1); send(8'h3C, 1'b1, 1'b1); send(8'h64, 1'b1, 1'b1);
        idle(1);
        check_slot("note_on", 0, 0, 7'd60, 7'd100);
        check_slot("slot1_empty", 0, 1, 7'd0, 7'd0);
        check_slot("chan_filter", 1, 0, 7'd0, 7'd0);

        // Running status with note-off via velocity 0
        do_reset();
        send(8'h90, 1'b1, 1'b1); send(8'h3C, 1'b1, 1'b1); send(8'h40, 1'b1, 1'b1);
        send(8'h40, 1'b1, 1'b1); send(8'h50, 1'b1, 1'b1);
        send(8'h3C, 1'b1, 1'b1); send(8'h00, 1'b1, 1'b1);
        idle(1);
        check_slot("rs_off", 0, 0, 7'd60, 7'd0);
        check_slot("rs_on", 0, 1, 7'd64, 7'd80);

        // Fill four slots, then steal slot0 and slot1
        do_reset();
        send(8'h90, 1'b1, 1'b1);
        for (int n = 60; n <= 64; n++) begin
            send(8'(n), 1'b1, 1'b1); send(8'h0A, 1'b1, 1'b1);
        end
        idle(1);
        check_slot("steal0", 0, 0, 7'd64, 7'd10);
        check_slot("fill3", 0, 3, 7'd63, 7'd10);
        send(8'h41, 1'b1, 1'b1); send(8'h0A, 1'b1, 1'b1);
        idle(1);
        check_slot("steal1", 0, 1, 7'd65, 7'd10);

        // Real-time byte inside a message; new status discards partial note-on
        do_reset();
        send(8'h90, 1'b1, 1'b1); send(8'h3C, 1'b1, 1'b1); send(8'hF8, 1'b1, 1'b1); send(8'h64, 1'b1, 1'b1);
        send(8'h90, 1'b1, 1'b1); send(8'h3E, 1'b1, 1'b1); send(8'h80, 1'b1, 1'b1);
        send(8'h3E, 1'b1, 1'b1); send(8'h40, 1'b1, 1'b1);
        idle(1);
        check_slot("rt_transparent", 0, 0, 7'd60, 7'd100);
        check_slot("partial_drop", 0, 1, 7'd0, 7'd0);

        // Program change and all-notes-off
        send(8'hC5, 1'b1, 1'b1); send(8'h12, 1'b1, 1'b1);
        send(8'h91, 1'b1, 1'b1); send(8'h3D, 1'b1, 1'b1); send(8'h64, 1'b1, 1'b1);
        send(8'hB0, 1'b1, 1'b1); send(8'h7B, 1'b1, 1'b1); send(8'h00, 1'b1, 1'b1);
        idle(1);
        total++;
        if (a_prog !== 7'd18) begin
            bad++;
            $display("FAIL program got=%0d want=18", a_prog);
        end
        check_slot("all_off0", 0, 0, 7'd60, 7'd0);
        check_slot("all_off1", 0, 1, 7'd61, 7'd0);
        check_slot("chan1_kept", 1, 0, 7'd61, 7'd100);

        // Reset between D1 and D2; the trailing data byte must be ignored
        do_reset();
        send(8'h90, 1'b1, 1'b1); send(8'h3C, 1'b1, 1'b1);
        do_reset();
        send(8'h64, 1'b1, 1'b1);
        idle(1);
        check_slot("post_reset_data", 0, 0, 7'd0, 7'd0);

        // Randomized stream with gaps, clock-enable holes and occasional resets
        for (int k = 0; k < 4000; k++) begin
            r = $urandom_range(0, 99);
            if (r < 22) b = sts[$urandom_range(0, 11)];
            else if (r < 25) b = 8'hF8 + 8'($urandom_range(0, 7));
            else if (r < 27) b = 8'hF0 + 8'($urandom_range(0, 7));
            else if (r < 32) b = ($urandom_range(0, 1) == 0) ? 8'd120 : 8'd123;
            else if (r < 40) b = 8'h00;
            else if (r < 75) b = 8'(60 + $urandom_range(0, 7));
            else b = 8'($urandom_range(0, 127));
            if ($urandom_range(0, 599) == 0) do_reset();
            send(b, $urandom_range(0, 99) < 85, $urandom_range(0, 99) < 90);
        end
        idle(3);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL sb_drain got=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
